uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver, the receive-side counterpart to the board's `txd` transmit path. Samples the asynchronous `rxd` pin, frames 8N1 characters (optionally 8E1), and buffers received bytes in a small FIFO. The FIFO is presented to the CPU-side memory-mapped peripheral logic through a valid/ready handshake. Framing and overrun faults are reported as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per bit (100 MHz / 115200); must be ≥ 8.
- `FIFO_DEPTH`, 4, receive FIFO entries; power of two, ≥ 2.
- `clk` in 1: single clock; all state on rising edge.
- `n_reset` in 1: reset, asynchronous, active-low.
- `rxd` in 1: serial input, idle high, asynchronous to `clk`.
- `rx_data` out 8: byte at FIFO head; valid only while `rx_valid`=1.
- `rx_valid` out 1: FIFO non-empty.
- `rx_ready` in 1: consumer pops the head when `rx_valid && rx_ready`.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `parity_err` out 1: one-cycle pulse on parity mismatch; tied 0 without `UART_RX_PARITY_EN`.
- `overrun` out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- `rxd` passes through a 2-FF synchronizer. The synchronizer FFs reset to 1. All logic uses the synchronized value `rxs`.
- Baud counter: counts 0..`CLKS_PER_BIT`-1. Bit counter: counts 0..7.
- FSM states are IDLE, START, DATA, PARITY (only with the macro), STOP, BREAK.
- IDLE: when `rxs`=0, clear the baud counter and go to START.
- START: wait `CLKS_PER_BIT/2` cycles (integer division), then sample. Sample 0: go to DATA. Sample 1: glitch; go to IDLE with no pulse.
- DATA: every `CLKS_PER_BIT` cycles, sample into the shift register, LSB first. After bit 7, go to PARITY (or STOP without the macro).
- PARITY: after `CLKS_PER_BIT` cycles, sample the bit and check even parity over the 8 data bits plus the parity bit. Go to STOP.
- STOP: after `CLKS_PER_BIT` cycles, sample.
  - Sample 1 and no parity error: push the byte, or pulse `overrun` if the FIFO cannot accept it. Go to IDLE.
  - Sample 1 and a parity error: pulse `parity_err`, discard the byte, go to IDLE.
  - Sample 0: pulse `frame_err`, discard the byte, go to BREAK. A parity error is not also reported in this case.
- BREAK: stay until `rxs`=1, then go to IDLE. This prevents a held-low line from re-triggering.
- FIFO: circular buffer with read and write pointers and an occupancy count of width clog2(`FIFO_DEPTH`)+1. `rx_data` reads the head combinationally from the storage array.
- Push and pop in the same cycle: the count is unchanged and both pointers advance.
  - If the FIFO is full, the push is accepted and no `overrun` is raised.
  - If the FIFO is empty, no pop occurs because `rx_valid`=0. The push completes and `rx_valid` rises the next cycle.
- Pointers wrap modulo `FIFO_DEPTH`.
- `rx_ready` is ignored while `rx_valid`=0.

## Timing
- Reset values:
  - FSM in IDLE; synchronizer at 1.
  - Pointers and count at 0.
  - `rx_valid`=0, `rx_data`=0, `frame_err`=`parity_err`=`overrun`=0.
- Reset mid-frame aborts immediately and discards the partial byte. After release, the FSM waits in IDLE for the next falling edge. A line still low at release starts a new frame.
- Detection latency: 2 cycles through the synchronizer, plus 1 cycle into START.
- Data bit k (0-based) is sampled at `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT` cycles after START entry.
- `rx_valid` rises 1 cycle after the stop-bit sample cycle. Error pulses are asserted in that same cycle.
- A pop clears `rx_valid` on the next cycle if the FIFO becomes empty.
- The FSM is back in IDLE 1 cycle after the stop sample. Back-to-back frames with zero idle time must be received.

## Configuration
- `UART_RX_PARITY_EN`
  - Defined: frame is 8E1. The PARITY state is compiled in and `parity_err` is driven as specified.
  - Undefined: frame is 8N1. The PARITY state and its logic are absent, and `parity_err` is constant 0.

## Test plan
All cases use `CLKS_PER_BIT`=16 and `FIFO_DEPTH`=4.
- Single byte 0xA5 (8N1), `rx_ready`=1 → `rx_valid` high for exactly 1 cycle, `rx_data`=0xA5, no error pulses.
- 0x00, 0xFF, 0x3C, 0x81, 0x55 sent back-to-back with `rx_ready`=0 → first four buffered; 5th causes one `overrun` pulse. Then `rx_ready`=1 pops 0x00, 0xFF, 0x3C, 0x81 in order, after which `rx_valid`=0.
- 0x5A sent with its stop bit driven 0, line held low 40 bit-times, then high → exactly one `frame_err` pulse; FIFO stays empty. A following 0x12 is received correctly.
- 3-cycle low glitch on an idle line → FSM returns to IDLE; no push, no pulses.
- `n_reset` asserted during bit 4 of 0x77, released, then 0x99 sent → only 0x99 appears.
- With `UART_RX_PARITY_EN`: 0x07 sent with parity bit 1 → received. 0x07 sent with parity bit 0 → one `parity_err` pulse, no push.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined) feeding a small FIFO. A byte is
// visible on rx_valid 1 cycle after its stop-bit sample; the FIFO drops new bytes (overrun) when full and not popping.
module uart_rx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overrun
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [PW:0]   CNT_FULL  = (PW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   state_t          r_state;
   logic            r_sync1, r_sync2;
   logic [BW-1:0]   r_baud;
   logic [2:0]      r_bit;
   logic [7:0]      r_shift;
   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [PW-1:0]   r_wr, r_rd;
   logic [PW:0]     r_count;
   logic            r_frame_err, r_overrun;
   logic            w_rxs, w_baud_done, w_stop_smp, w_par_err;
   logic            w_good, w_full, w_push, w_pop;

   assign w_rxs       = r_sync2;
   assign w_baud_done = (r_baud == BAUD_LAST);
   assign w_stop_smp  = (r_state == S_STOP) && w_baud_done;
   assign w_full      = (r_count == CNT_FULL);
   assign w_pop       = rx_valid && rx_ready;
   assign w_good      = w_stop_smp && w_rxs && !w_par_err;
   // A full FIFO still takes the byte when the head leaves in the same cycle.
   assign w_push      = w_good && (!w_full || w_pop);

   assign rx_valid  = (r_count != '0);
   assign rx_data   = r_mem[r_rd];
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

`ifdef UART_RX_PARITY_EN
   logic r_par, r_parity_err;
   assign w_par_err  = ^{r_shift, r_par};
   assign parity_err = r_parity_err;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_parity_err <= 1'b0;
      end else begin
         r_parity_err <= w_stop_smp && w_rxs && w_par_err;
      end
   end
`else
   assign w_par_err  = 1'b0;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rxd;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state     <= S_IDLE;
         r_baud      <= '0;
         r_bit       <= '0;
         r_shift     <= '0;
`ifdef UART_RX_PARITY_EN
         r_par       <= 1'b0;
`endif
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_stop_smp && !w_rxs;
         r_overrun   <= w_good && w_full && !w_pop;
         case (r_state)
            S_IDLE: begin
               if (!w_rxs) begin
                  r_baud  <= '0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (r_baud == HALF_LAST) begin
                  r_baud  <= '0;
                  r_bit   <= '0;
                  r_state <= w_rxs ? S_IDLE : S_DATA;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            S_DATA: begin
               if (w_baud_done) begin
                  r_baud  <= '0;
                  r_shift <= {w_rxs, r_shift[7:1]};
                  r_bit   <= r_bit + 1'b1;
                  if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= S_PARITY;
`else
                     r_state <= S_STOP;
`endif
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (w_baud_done) begin
                  r_baud  <= '0;
                  r_par   <= w_rxs;
                  r_state <= S_STOP;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (w_baud_done) begin
                  r_baud  <= '0;
                  r_state <= w_rxs ? S_IDLE : S_BREAK;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            S_BREAK: begin
               if (w_rxs) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= r_shift;
            r_wr        <= r_wr + 1'b1;
         end
         if (w_pop) r_rd <= r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed bench for uart_rx at CLKS_PER_BIT=16, FIFO_DEPTH=4 against a frame-level model.
module tb_uart_rx;
   localparam int CPB = 16;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       n_reset;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err, parity_err, overrun;

   int n_cmp = 0;
   int n_fail = 0;
   int n_ferr, n_perr, n_ovr, n_vcyc;
   logic [7:0] popped[$];
   logic [7:0] exp_q[$];

   uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .n_reset(n_reset), .rxd(rxd),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (n_reset) begin
         if (frame_err)  n_ferr++;
         if (parity_err) n_perr++;
         if (overrun)    n_ovr++;
         if (rx_valid)   n_vcyc++;
         if (rx_valid && rx_ready) popped.push_back(rx_data);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      n_ferr = 0; n_perr = 0; n_ovr = 0; n_vcyc = 0;
      popped.delete();
      exp_q.delete();
   endtask

   task automatic send_bit(input logic b);
      rxd = b;
      tick(CPB);
   endtask

   // Full frame; the parity bit is only put on the wire in an 8E1 build.
   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(par);
`else
      if (par === 1'bx) $display("unused parity argument");
`endif
      send_bit(stop);
      rxd = 1'b1;
   endtask

   task automatic check_popped(input string name);
      if (popped.size() !== exp_q.size()) begin
         $display("FAIL %s count: got %0d want %0d", name, popped.size(), exp_q.size());
         n_fail++;
      end
      n_cmp++;
      for (int i = 0; i < exp_q.size() && i < popped.size(); i++) begin
         if (popped[i] !== exp_q[i]) begin
            $display("FAIL %s byte%0d: got %h want %h", name, i, popped[i], exp_q[i]);
            n_fail++;
         end
         n_cmp++;
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      if (got !== want) begin
         $display("FAIL %s: got %0d want %0d", name, got, want);
         n_fail++;
      end
      n_cmp++;
   endtask

   task automatic test_reset();
      n_reset = 1'b0; rxd = 1'b1; rx_ready = 1'b0;
      tick(3);
      if (rx_valid !== 1'b0) begin $display("FAIL reset rx_valid: got %b want 0", rx_valid); n_fail++; end
      n_cmp++;
      if (rx_data !== 8'h00) begin $display("FAIL reset rx_data: got %h want 00", rx_data); n_fail++; end
      n_cmp++;
      if ({frame_err, parity_err, overrun} !== 3'b000) begin
         $display("FAIL reset pulses: got %b want 000", {frame_err, parity_err, overrun}); n_fail++;
      end
      n_cmp++;
      n_reset = 1'b1;
      tick(4);
      clear_obs();
   endtask

   task automatic test_single();
      clear_obs();
      rx_ready = 1'b1;
      send_frame(8'hA5, 1'b0, 1'b1);
      exp_q.push_back(8'hA5);
      tick(2 * CPB);
      check_popped("single");
      check_int("single valid_cycles", n_vcyc, 1);
      check_int("single pulses", n_ferr + n_perr + n_ovr, 0);
   endtask

   task automatic test_random();
      logic [7:0] b;
      clear_obs();
      rx_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         b = 8'($urandom);
         send_frame(b, ^b, 1'b1);
         exp_q.push_back(b);
         tick($urandom_range(0, 20));
      end
      tick(2 * CPB);
      check_popped("random");
      check_int("random pulses", n_ferr + n_perr + n_ovr, 0);
   endtask

   task automatic test_back_to_back();
      logic [7:0] vals[5] = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h55};
      int exp_ovr = 0;
      clear_obs();
      rx_ready = 1'b0;
      foreach (vals[i]) begin
         send_frame(vals[i], ^vals[i], 1'b1);
         if (exp_q.size() < DEPTH) exp_q.push_back(vals[i]);
         else exp_ovr++;
      end
      tick(2 * CPB);
      check_int("b2b overrun", n_ovr, exp_ovr);
      check_int("b2b rx_valid held", int'(rx_valid), 1);
      rx_ready = 1'b1;
      tick(10);
      check_popped("b2b drain");
      check_int("b2b rx_valid empty", int'(rx_valid), 0);
   endtask

   task automatic test_frame_error();
      clear_obs();
      rx_ready = 1'b1;
      send_frame(8'h5A, ^8'h5A, 1'b0);
      rxd = 1'b0;
      tick(40 * CPB);
      rxd = 1'b1;
      tick(2 * CPB);
      check_int("frame_err pulses", n_ferr, 1);
      check_int("frame_err no push", n_vcyc, 0);
      send_frame(8'h12, ^8'h12, 1'b1);
      exp_q.push_back(8'h12);
      tick(2 * CPB);
      check_popped("after break");
      check_int("after break frame_err", n_ferr, 1);
   endtask

   task automatic test_glitch();
      clear_obs();
      rx_ready = 1'b1;
      rxd = 1'b0;
      tick(3);
      rxd = 1'b1;
      tick(15 * CPB);
      check_int("glitch valid", n_vcyc, 0);
      check_int("glitch pulses", n_ferr + n_perr + n_ovr, 0);
   endtask

   task automatic test_reset_midframe();
      logic [7:0] b = 8'h77;
      clear_obs();
      rx_ready = 1'b1;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(b[i]);
      rxd = b[4];
      tick(CPB / 2);
      n_reset = 1'b0;
      tick(3);
      n_reset = 1'b1;
      rxd = 1'b1;
      tick(12 * CPB);
      send_frame(8'h99, ^8'h99, 1'b1);
      exp_q.push_back(8'h99);
      tick(2 * CPB);
      check_popped("reset midframe");
      check_int("reset midframe pulses", n_ferr + n_perr + n_ovr, 0);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      clear_obs();
      rx_ready = 1'b1;
      send_frame(8'h07, 1'b1, 1'b1);
      exp_q.push_back(8'h07);
      tick(CPB);
      send_frame(8'h07, 1'b0, 1'b1);
      tick(2 * CPB);
      check_popped("parity");
      check_int("parity_err pulses", n_perr, 1);
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_random();
      test_back_to_back();
      test_frame_error();
      test_glitch();
      test_reset_midframe();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
